uart_tx_fifo: RTL and testbench

Serial transmitter that drains the 8051 core's synchronous transmit FIFO (`syn_fifo`) and shifts each byte out as an 8N1 UART frame. It sits directly downstream of the FIFO's read port: it watches `is_empty`, issues single-cycle `r_en` pops, captures `r_data`, and drives the `txd` pin. Baud timing comes from a fixed clock divisor, with one bit every `CLK_DIV` clocks.

---
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter that pops bytes from a synchronous FIFO (one-cycle read latency)
// and shifts them out LSB first, one bit every CLK_DIV clocks.
//
// state | meaning
// IDLE  | line high, waiting for tx_en with a non-empty FIFO
// FETCH | r_en high for this single cycle
// LOAD  | r_data valid, captured into the shift register at the closing edge
// START | start bit (txd low) for CLK_DIV clocks
// DATA  | DATA_WIDTH data bits, LSB first, CLK_DIV clocks each
// STOP  | stop bit (txd high), tx_done on its last cycle
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  is_empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BIT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] BAUD_ONE  = CNT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] BIT_LAST  = BIT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0] BIT_ONE   = BIT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  baud_cnt;
    logic [CNT_WIDTH-1:0]  baud_cnt_next;
    logic [BIT_WIDTH-1:0]  bit_cnt;
    logic [BIT_WIDTH-1:0]  bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  txd_next;
    logic                  r_en_next;
    logic                  tx_done_next;
    logic                  baud_last;
    logic                  frame_req;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign frame_req = tx_en && !is_empty;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            r_en     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            txd      <= txd_next;
            r_en     <= r_en_next;
            tx_done  <= tx_done_next;
        end
    end

    // Outputs are registered from the next-state values so they line up exactly
    // with the state they belong to, without a combinational path to the pins.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        txd_next      = 1'b1;
        r_en_next     = 1'b0;
        tx_done_next  = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                if (frame_req) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                shift_next    = r_data;
                baud_cnt_next = '0;
                state_next    = START;
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    shift_next    = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_ONE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    state_next    = frame_req ? FETCH : IDLE;
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_ONE;
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
            end
        endcase

        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            default: txd_next = 1'b1;
        endcase

        r_en_next    = (state_next == FETCH);
        tx_done_next = (state_next == STOP) && (baud_cnt_next == BAUD_LAST);
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_DIV=4: a one-cycle-latency FIFO model feeds the
// DUT and each frame on txd is captured cycle by cycle and decoded.
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       tx_en  = 1'b0;
    logic       is_empty;
    logic       r_en;
    logic [7:0] r_data = 8'h00;
    logic       txd;
    logic       busy;
    logic       tx_done;

    uart_tx_fifo #(
        .DATA_WIDTH(8),
        .CLK_DIV   (DIV),
        .CNT_WIDTH (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_en   (tx_en),
        .is_empty(is_empty),
        .r_en    (r_en),
        .r_data  (r_data),
        .txd     (txd),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on r_data the edge after r_en is sampled
    logic [7:0] fifo_mem [0:63];
    logic [5:0] wr_ptr = 6'd0;
    logic [5:0] rd_ptr = 6'd0;

    assign is_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (r_en && !is_empty) begin
            r_data <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 6'd1;
        end
    end

    int cyc = 0, ren_cnt = 0, done_cnt = 0, underflow_cnt = 0;
    int busy_hi_cnt = 0, busy_lo_cnt = 0, txd_lo_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (r_en) ren_cnt++;
        if (r_en && is_empty) underflow_cnt++;
        if (tx_done) done_cnt++;
        if (busy) busy_hi_cnt++;
        else busy_lo_cnt++;
        if (!txd) txd_lo_cnt++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    logic [7:0] fr_data;
    logic       fr_ok;
    int         fr_done_idx, fr_done_n, fr_wait, fr_start;

    // Called on a negedge; waits for the start bit, then samples all 40 frame cycles.
    task automatic get_frame();
        logic [FRAME-1:0] bits;
        logic [FRAME-1:0] tmp;
        int w;
        bits = '0;
        w = 0;
        fr_done_n = 0;
        fr_done_idx = -1;
        fr_ok = 1'b0;
        fr_data = '0;
        while (txd !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        fr_wait = w;
        fr_start = cyc;
        if (txd !== 1'b0) begin
            chk("frame_start_seen", 32'(txd), 0);
            return;
        end
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            bits = {txd, bits[FRAME-1:1]};
            if (tx_done) begin
                fr_done_n++;
                fr_done_idx = c;
            end
        end
        fr_ok = 1'b1;
        for (int s = 0; s < 10; s++) begin
            tmp = bits >> (s * DIV);
            if (tmp[DIV-1:0] != '0 && tmp[DIV-1:0] != '1) fr_ok = 1'b0;
            if (s == 0 && tmp[0] != 1'b0) fr_ok = 1'b0;
            if (s == 9 && tmp[0] != 1'b1) fr_ok = 1'b0;
            if (s >= 1 && s <= 8) fr_data = {tmp[0], fr_data[7:1]};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d limit=100000", cyc);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_rnd [0:15];

    initial begin
        int r0, d0, b0, s0, t0, h0, w, bad;

        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 1);
        chk("reset_r_en", 32'(r_en), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_tx_done", 32'(tx_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte 0xA5
        push(8'hA5);
        r0 = ren_cnt;
        d0 = done_cnt;
        tx_en = 1'b1;
        get_frame();
        chk("a5_latency", fr_wait, 3);
        chk("a5_data", 32'(fr_data), 'hA5);
        chk("a5_framing", 32'(fr_ok), 1);
        chk("a5_done_idx", fr_done_idx, 39);
        chk("a5_done_n", fr_done_n, 1);
        repeat (20) @(negedge clk);
        chk("a5_pops", ren_cnt - r0, 1);
        chk("a5_done_total", done_cnt - d0, 1);
        chk("a5_busy_after", 32'(busy), 0);
        chk("a5_txd_idle", 32'(txd), 1);

        // back-to-back 0x00, 0xFF, 0x3C
        tx_en = 1'b0;
        @(negedge clk);
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        r0 = ren_cnt;
        d0 = done_cnt;
        tx_en = 1'b1;
        get_frame();
        s0 = fr_start;
        b0 = busy_lo_cnt;
        chk("b2b0_data", 32'(fr_data), 'h00);
        chk("b2b0_framing", 32'(fr_ok), 1);
        get_frame();
        chk("b2b1_data", 32'(fr_data), 'hFF);
        chk("b2b1_framing", 32'(fr_ok), 1);
        chk("b2b1_period", fr_start - s0, 42);
        s0 = fr_start;
        get_frame();
        chk("b2b2_data", 32'(fr_data), 'h3C);
        chk("b2b2_framing", 32'(fr_ok), 1);
        chk("b2b2_period", fr_start - s0, 42);
        chk("b2b_busy_drops", busy_lo_cnt - b0, 0);
        repeat (10) @(negedge clk);
        chk("b2b_done_total", done_cnt - d0, 3);
        chk("b2b_pops", ren_cnt - r0, 3);
        chk("b2b_empty_end", 32'(is_empty), 1);
        chk("b2b_busy_after", 32'(busy), 0);

        // empty FIFO with tx_en held high
        r0 = ren_cnt;
        t0 = txd_lo_cnt;
        h0 = busy_hi_cnt;
        repeat (100) @(negedge clk);
        chk("empty_pops", ren_cnt - r0, 0);
        chk("empty_txd_low", txd_lo_cnt - t0, 0);
        chk("empty_busy_high", busy_hi_cnt - h0, 0);

        // tx_en dropped during the first frame's DATA bits
        tx_en = 1'b0;
        @(negedge clk);
        push(8'h5A);
        push(8'hC3);
        r0 = ren_cnt;
        tx_en = 1'b1;
        fork
            get_frame();
            begin
                repeat (12) @(negedge clk);
                tx_en = 1'b0;
            end
        join
        chk("gate_data", 32'(fr_data), 'h5A);
        chk("gate_framing", 32'(fr_ok), 1);
        repeat (30) @(negedge clk);
        chk("gate_pops_held", ren_cnt - r0, 1);
        chk("gate_busy_held", 32'(busy), 0);
        chk("gate_not_empty", 32'(is_empty), 0);
        tx_en = 1'b1;
        get_frame();
        chk("gate_resume_data", 32'(fr_data), 'hC3);
        chk("gate_resume_framing", 32'(fr_ok), 1);
        @(negedge clk);
        chk("gate_pops_total", ren_cnt - r0, 2);

        // reset in the middle of data bit 3 of 0x81 (a 0 bit)
        tx_en = 1'b0;
        @(negedge clk);
        push(8'h81);
        push(8'h96);
        r0 = ren_cnt;
        tx_en = 1'b1;
        w = 0;
        while (txd !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("rst_start_seen", 32'(txd), 0);
        repeat (17) @(negedge clk);
        chk("rst_pre_txd", 32'(txd), 0);
        chk("rst_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_txd", 32'(txd), 1);
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_r_en", 32'(r_en), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        get_frame();
        chk("rst_next_latency", fr_wait, 3);
        chk("rst_next_data", 32'(fr_data), 'h96);
        chk("rst_next_framing", 32'(fr_ok), 1);
        @(negedge clk);
        chk("rst_pops", ren_cnt - r0, 2);

        // 16 random bytes drained in order
        tx_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp_rnd[i[3:0]] = 8'($urandom_range(0, 255));
            push(exp_rnd[i[3:0]]);
        end
        r0 = ren_cnt;
        bad = 0;
        tx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            get_frame();
            chk($sformatf("rnd%0d_data", i), 32'(fr_data), 32'(exp_rnd[i[3:0]]));
            if (fr_ok !== 1'b1) bad++;
        end
        chk("rnd_framing_bad", bad, 0);
        repeat (20) @(negedge clk);
        chk("rnd_pops", ren_cnt - r0, 16);
        chk("rnd_empty_end", 32'(is_empty), 1);
        chk("no_underflow", underflow_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
